pixel_stream_source: RTL and testbench

PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

---
 rtl/pixel_stream_pkg.sv | 29 ++
 rtl/pixel_stream_if.sv | 31 +++
 rtl/raster_counter.sv | 60 ++++++
 rtl/pixel_stream_source.sv | 182 ++++++++++++++++++
 tb/tb_pixel_stream_source.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pixel_stream_pkg.sv
// pixel_stream_pkg
// Shared definitions for the pixel stream source slice:
//   X_W / Y_W  widths of the signed pixel coordinates handed downstream
//   state_e    sequencer state encoding
//   BAR_RGB    colour-bar table, index 0 = leftmost bar, packed {R,G,B}
package pixel_stream_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Index 0 sits in the low 24 bits: white, yellow, cyan, green,
  // magenta, red, blue, black from left to right on screen.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000,
    24'h0000FF,
    24'hFF0000,
    24'hFF00FF,
    24'h00FF00,
    24'h00FFFF,
    24'hFFFF00,
    24'hFFFFFF
  };

endpackage

// File: rtl/pixel_stream_if.sv
// pixel_stream_if
// Pixel output bus from the source to the renderer chain.
//   x_out, y_out                 signed pixel coordinate
//   r_out, g_out, b_out          pixel colour
//   pixel_valid                  visible pixel
//   line_start                   first pixel of a visible line
//   frame_start                  first pixel of a frame
// Modports: master (source drives), slave (renderer samples).
interface pixel_stream_if;
  import pixel_stream_pkg::*;

  logic signed [X_W-1:0] x_out;
  logic signed [Y_W-1:0] y_out;
  logic [7:0]            r_out;
  logic [7:0]            g_out;
  logic [7:0]            b_out;
  logic                  pixel_valid;
  logic                  line_start;
  logic                  frame_start;

  modport master (
    output x_out, y_out, r_out, g_out, b_out,
           pixel_valid, line_start, frame_start
  );

  modport slave (
    input  x_out, y_out, r_out, g_out, b_out,
           pixel_valid, line_start, frame_start
  );

endinterface

// File: rtl/raster_counter.sv
// raster_counter
// Horizontal/vertical raster position counters with line and frame wrap.
//   clk, rst      clock, async active-high reset
//   advance_i     step one pixel this cycle
//   h_o, v_o      current raster position
//   frame_end_o   position is the last pixel of the frame
module raster_counter
  import pixel_stream_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int HW      = X_W - 1,
  parameter int VW      = Y_W - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          frame_end_o
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;

  assign h_last = (h_q == H_LAST);
  assign v_last = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (advance_i) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o         = h_q;
  assign v_o         = v_q;
  assign frame_end_o = h_last & v_last;

endmodule

// File: rtl/pixel_stream_source.sv
// pixel_stream_source
// Free-running raster pixel source: sequences whole frames while enabled
// and emits registered coordinate, colour and qualifier outputs.
//   clk, rst   clock, async active-high reset
//   enable     run request, sampled at frame boundaries once running
//   px         pixel_stream_if.master output bus
// Optional build macro PIXEL_STREAM_TEST_PATTERN_EN replaces the background
// colour with eight vertical colour bars.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | counters parked at (0,0), outputs held at zero
// ST_RUN  | counters stepping every cycle, stop only at frame end
module pixel_stream_source
  import pixel_stream_pkg::*;
#(
  parameter int         H_ACTIVE = 640,
  parameter int         H_BLANK  = 160,
  parameter int         V_ACTIVE = 480,
  parameter int         V_BLANK  = 45,
  parameter logic [7:0] BG_R     = 8'h00,
  parameter logic [7:0] BG_G     = 8'h00,
  parameter logic [7:0] BG_B     = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  pixel_stream_if.master px
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  // Coordinates are zero-extended, so the counters lose the sign bit.
  localparam int HW = X_W - 1;
  localparam int VW = Y_W - 1;

  if (H_ACTIVE < 1 || V_ACTIVE < 1 || H_BLANK < 0 || V_BLANK < 0) begin : g_bad_dims
    $error("pixel_stream_source: active sizes must be positive, blanking non-negative");
  end
  if (H_TOTAL > (1 << HW)) begin : g_bad_h
    $error("pixel_stream_source: H_ACTIVE+H_BLANK exceeds x_out range");
  end
  if (V_TOTAL > (1 << VW)) begin : g_bad_v
    $error("pixel_stream_source: V_ACTIVE+V_BLANK exceeds y_out range");
  end

  state_e        state_q, state_d;
  logic          run;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          frame_end;

  assign run = (state_q == ST_RUN);

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .HW      (HW),
    .VW      (VW)
  ) u_raster (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (run),
    .h_o         (h),
    .v_o         (v),
    .frame_end_o (frame_end)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_RUN;
      ST_RUN:  if (frame_end && !enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  logic        h_act, v_act;
  logic [23:0] pix_rgb;

  assign h_act = ({1'b0, h} < X_W'(H_ACTIVE));
  assign v_act = ({1'b0, v} < Y_W'(V_ACTIVE));

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
  // Bar width clamps to one pixel for very narrow lines; the bar index
  // saturates at the last bar so any remainder of H_ACTIVE/8 stays black.
  localparam int            BAR_W_INT = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
  localparam logic [HW-1:0] BAR_LAST  = HW'(BAR_W_INT - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);

  logic [HW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  // Sub-counter tracks the current h, so its reset lines up with h wrapping.
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (run) begin
      if (h == H_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
      end else if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  assign pix_rgb = BAR_RGB[bar_idx_q];
`else
  assign pix_rgb = {BG_R, BG_G, BG_B};
`endif

  logic signed [X_W-1:0] x_q, x_d;
  logic signed [Y_W-1:0] y_q, y_d;
  logic [23:0]           rgb_q, rgb_d;
  logic                  valid_q, valid_d;
  logic                  lstart_q, lstart_d;
  logic                  fstart_q, fstart_d;

  always_comb begin
    x_d      = '0;
    y_d      = '0;
    rgb_d    = '0;
    valid_d  = 1'b0;
    lstart_d = 1'b0;
    fstart_d = 1'b0;
    if (run) begin
      x_d      = {1'b0, h};
      y_d      = {1'b0, v};
      valid_d  = h_act & v_act;
      lstart_d = (h == '0) & v_act;
      fstart_d = (h == '0) & (v == '0);
      rgb_d    = (h_act & v_act) ? pix_rgb : 24'h000000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      rgb_q    <= '0;
      valid_q  <= 1'b0;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      rgb_q    <= rgb_d;
      valid_q  <= valid_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
    end
  end

  assign px.x_out       = x_q;
  assign px.y_out       = y_q;
  assign px.r_out       = rgb_q[23:16];
  assign px.g_out       = rgb_q[15:8];
  assign px.b_out       = rgb_q[7:0];
  assign px.pixel_valid = valid_q;
  assign px.line_start  = lstart_q;
  assign px.frame_start = fstart_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// tb_pixel_stream_source
// Directed bench for pixel_stream_source on a 4+2 by 3+1 raster.
// With PIXEL_STREAM_TEST_PATTERN_EN defined a second, 16-pixel-wide
// instance exercises the colour bars.
module tb_pixel_stream_source;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 1;
  localparam int HT = HA + HB;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic enable2;

  int n_checks = 0;
  int n_pass   = 0;

  logic [23:0] bars [8];

  always #5 clk = ~clk;

  pixel_stream_if px1 ();

  pixel_stream_source #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_BLANK  (VB),
    .BG_R     (8'h12),
    .BG_G     (8'h34),
    .BG_B     (8'h56)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .px     (px1)
  );

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
  pixel_stream_if px2 ();

  pixel_stream_source #(
    .H_ACTIVE (16),
    .H_BLANK  (2),
    .V_ACTIVE (3),
    .V_BLANK  (1)
  ) dut_pat (
    .clk    (clk),
    .rst    (rst),
    .enable (enable2),
    .px     (px2)
  );
`endif

  function automatic logic [49:0] obs1();
    return {px1.x_out, px1.y_out, px1.r_out, px1.g_out, px1.b_out,
            px1.pixel_valid, px1.line_start, px1.frame_start};
  endfunction

  // Expected colour for the 4-wide instance: background, or one-pixel bars.
  function automatic logic [23:0] exp_rgb(input int x);
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    return bars[x];
`else
    return 24'h123456;
`endif
  endfunction

  function automatic logic [49:0] exp_vec(input int x, input int y);
    logic        pv, ls, fs;
    logic [23:0] rgb;
    pv  = (x < HA) && (y < VA);
    ls  = (x == 0) && (y < VA);
    fs  = (x == 0) && (y == 0);
    rgb = pv ? exp_rgb(x) : 24'h000000;
    return {11'(x), 12'(y), rgb, pv, ls, fs};
  endfunction

  task automatic chk(input string tag, input logic [49:0] obs, input logic [49:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_pix(input string tag, input int k);
    chk($sformatf("%s(%0d,%0d)", tag, k % HT, k / HT), obs1(), exp_vec(k % HT, k / HT));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

    rst     = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;

    // Reset clears outputs before any clock edge.
    #2 rst = 1'b1;
    #1 chk("rst_async", obs1(), 50'h0);
    step(1);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_hold", obs1(), 50'h0);
    end

    // First frame: (0,0) two edges after enable, 24 cycles per frame.
    enable = 1'b1;
    step(2);
    for (int k = 0; k < 24; k++) begin
      chk_pix("frame1", k);
      step(1);
    end

    // Second frame starts without a gap; drop enable at (1,1).
    for (int k = 0; k < 8; k++) begin
      chk_pix(k == 0 ? "wrap" : "frame2", k);
      if (k == 7) enable = 1'b0;
      step(1);
    end
    for (int k = 8; k < 24; k++) begin
      chk_pix("stop_finish", k);
      step(1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("stop_idle", obs1(), 50'h0);
      step(1);
    end

    // Reset mid-frame at (2,1), then restart from (0,0).
    enable = 1'b1;
    step(2);
    for (int k = 0; k <= 8; k++) begin
      chk_pix("pre_rst", k);
      if (k < 8) step(1);
    end
    rst = 1'b1;
    #1 chk("rst_mid", obs1(), 50'h0);
    step(2);
    chk("rst_hold", obs1(), 50'h0);
    rst = 1'b0;
    step(2);
    chk_pix("restart", 0);
    step(1);
    chk_pix("restart", 1);
    enable = 1'b0;

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    // 16-wide instance: bars two pixels wide, then blanking.
    enable2 = 1'b1;
    step(2);
    for (int x = 0; x < 18; x++) begin
      chk($sformatf("pattern_x%0d", x),
          {26'h0, px2.r_out, px2.g_out, px2.b_out},
          {26'h0, (x < 16) ? bars[x / 2] : 24'h000000});
      step(1);
    end
    enable2 = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
